// File: rtl/cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit
//
// Coprocessor-0 exception/interrupt unit sitting at the M stage. It decides
// whether the M-stage instruction takes an exception or an external interrupt,
// records SR / Cause / EPC, raises the pipeline flush request, and serves
// mfc0 / mtc0 / eret.
//
// Ports:
//   clk         in   1   system clock, rising-edge active
//   reset_n     in   1   asynchronous active-low reset
//   Exc_in      in   1   M-stage instruction carries an exception
//   ExcCode_in  in   5   exception code of that instruction
//   BD_in       in   1   M-stage instruction sits in a branch delay slot
//   PC_in       in  32   M-stage instruction PC
//   HWInt       in   6   level-sensitive external interrupt lines
//   CP0_we      in   1   mtc0 write strobe
//   CP0_addr    in   5   CP0 register number (read and write)
//   CP0_wdata   in  32   mtc0 write data
//   eret        in   1   M-stage instruction is eret
//   CP0_rdata   out 32   mfc0 read data (combinational, no write bypass)
//   Req         out  1   take exception/interrupt this cycle (flush)
//   EPC_out     out 32   current EPC register, eret target
//   Handler_PC  out 32   exception entry address
// -----------------------------------------------------------------------------
module cp0_exception_unit #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Exc_in,
  input  logic [4:0]  ExcCode_in,
  input  logic        BD_in,
  input  logic [31:0] PC_in,
  input  logic [5:0]  HWInt,
  input  logic        CP0_we,
  input  logic [4:0]  CP0_addr,
  input  logic [31:0] CP0_wdata,
  input  logic        eret,
  output logic [31:0] CP0_rdata,
  output logic        Req,
  output logic [31:0] EPC_out,
  output logic [31:0] Handler_PC
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Architectural state: only the implemented fields are stored.
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_aligned;
  logic [31:0] epc_next;

  // Interrupts win over the instruction's own exception; EXL masks both.
  assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = Exc_in & ~sr_exl;
  assign Req     = int_req | exc_req;

  // A delay-slot instruction restarts at its branch; wraps modulo 2^32.
  assign pc_aligned = {PC_in[31:2], 2'b00};
  assign epc_next   = BD_in ? (pc_aligned - 32'd4) : pc_aligned;

  assign EPC_out    = epc;
  assign Handler_PC = HANDLER_PC;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // races between the request logic and the state it reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      // Pending-interrupt view is a plain one-cycle sample of the lines.
      cause_ip <= HWInt;

      if (Req) begin
        // Taking the request discards any same-cycle mtc0 or eret.
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCode_in;
        cause_bd  <= BD_in;
        epc       <= epc_next;
      end else begin
        if (eret) sr_exl <= 1'b0;
        if (CP0_we) begin
          case (CP0_addr)
            ADDR_SR: begin
              sr_im <= CP0_wdata[15:10];
              sr_ie <= CP0_wdata[0];
              // eret owns EXL when both arrive together.
              if (!eret) sr_exl <= CP0_wdata[1];
            end
            ADDR_EPC: epc <= CP0_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // NOTE: the read mux assigns a default before the case so every path
  // drives CP0_rdata; without it unlisted addresses would infer a latch.
  always_comb begin
    CP0_rdata = 32'd0;
    case (CP0_addr)
      ADDR_SR:    CP0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      ADDR_CAUSE: CP0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      ADDR_EPC:   CP0_rdata = epc;
      ADDR_PRID:  CP0_rdata = PRID;
      default:    CP0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exception_unit
//
// Directed bench for cp0_exception_unit. Each step pushes its expected value
// onto a scoreboard queue as the stimulus is applied; the value is popped and
// compared once the DUT output is sampled (#1 after a drive or after an edge).
// -----------------------------------------------------------------------------
module tb_cp0_exception_unit;

  localparam logic [31:0] TB_PRID = 32'h0001_8000;

  logic        clk;
  logic        reset_n;
  logic        Exc_in;
  logic [4:0]  ExcCode_in;
  logic        BD_in;
  logic [31:0] PC_in;
  logic [5:0]  HWInt;
  logic        CP0_we;
  logic [4:0]  CP0_addr;
  logic [31:0] CP0_wdata;
  logic        eret;
  logic [31:0] CP0_rdata;
  logic        Req;
  logic [31:0] EPC_out;
  logic [31:0] Handler_PC;

  cp0_exception_unit #(
    .HANDLER_PC (32'h0000_4180),
    .PRID       (TB_PRID)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Exc_in     (Exc_in),
    .ExcCode_in (ExcCode_in),
    .BD_in      (BD_in),
    .PC_in      (PC_in),
    .HWInt      (HWInt),
    .CP0_we     (CP0_we),
    .CP0_addr   (CP0_addr),
    .CP0_wdata  (CP0_wdata),
    .eret       (eret),
    .CP0_rdata  (CP0_rdata),
    .Req        (Req),
    .EPC_out    (EPC_out),
    .Handler_PC (Handler_PC)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    Exc_in     = 1'b0;
    ExcCode_in = 5'd0;
    BD_in      = 1'b0;
    PC_in      = 32'd0;
    CP0_we     = 1'b0;
    CP0_addr   = 5'd0;
    CP0_wdata  = 32'd0;
    eret       = 1'b0;
  endtask

  // Let one rising edge happen, then return the inputs to idle.
  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    CP0_addr = addr;
    expect_val(tag, exp);
    #1;
    check(CP0_rdata);
  endtask

  task automatic req_chk(input string tag, input logic exp);
    expect_val(tag, {31'd0, exp});
    #1;
    check({31'd0, Req});
  endtask

  task automatic drive_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    @(negedge clk);
    Exc_in     = 1'b1;
    ExcCode_in = code;
    PC_in      = pc;
    BD_in      = bd;
  endtask

  task automatic do_eret();
    @(negedge clk);
    eret = 1'b1;
    cycle();
  endtask

  initial begin
    // Reset held with busy inputs (Exc_in low so Req must read 0).
    reset_n    = 1'b0;
    HWInt      = 6'h3F;
    Exc_in     = 1'b0;
    ExcCode_in = 5'd12;
    BD_in      = 1'b1;
    PC_in      = 32'h1234_5678;
    CP0_we     = 1'b1;
    CP0_wdata  = 32'hFFFF_FFFF;
    eret       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    read_chk("rst_sr", 5'd12, 32'd0);
    read_chk("rst_cause", 5'd13, 32'd0);
    read_chk("rst_epc", 5'd14, 32'd0);
    req_chk("rst_req", 1'b0);
    expect_val("rst_epc_out", 32'd0);
    check(EPC_out);
    expect_val("handler_pc", 32'h0000_4180);
    check(Handler_PC);

    @(negedge clk);
    idle();
    HWInt   = 6'd0;
    reset_n = 1'b1;
    cycle();
    read_chk("post_rst_sr", 5'd12, 32'd0);
    read_chk("post_rst_cause", 5'd13, 32'd0);
    read_chk("post_rst_epc", 5'd14, 32'd0);

    // Overflow exception.
    drive_exc(5'd12, 32'h0000_3010, 1'b0);
    req_chk("ov_req", 1'b1);
    cycle();
    read_chk("ov_epc", 5'd14, 32'h0000_3010);
    read_chk("ov_cause", 5'd13, 32'h0000_0030);
    read_chk("ov_sr", 5'd12, 32'h0000_0002);
    do_eret();
    read_chk("eret1_sr", 5'd12, 32'd0);

    // Delay-slot exception.
    drive_exc(5'd4, 32'h0000_3014, 1'b1);
    req_chk("bd_req", 1'b1);
    cycle();
    read_chk("bd_epc", 5'd14, 32'h0000_3010);
    read_chk("bd_cause", 5'd13, 32'h8000_0010);
    do_eret();

    // Enable interrupt line 0 via mtc0 SR.
    @(negedge clk);
    CP0_we    = 1'b1;
    CP0_addr  = 5'd12;
    CP0_wdata = 32'h0000_0401;
    req_chk("mtc0_sr_req", 1'b0);
    cycle();
    read_chk("mtc0_sr", 5'd12, 32'h0000_0401);

    // Interrupt beats the simultaneous exception; recorded code is 0.
    drive_exc(5'd5, 32'h0000_3020, 1'b0);
    HWInt = 6'b000001;
    req_chk("int_req", 1'b1);
    cycle();
    read_chk("int_cause", 5'd13, 32'h0000_0400);
    read_chk("int_sr", 5'd12, 32'h0000_0403);
    read_chk("int_epc", 5'd14, 32'h0000_3020);

    // Same interrupt with EXL set: masked.
    drive_exc(5'd5, 32'h0000_3024, 1'b0);
    req_chk("int_exl_req", 1'b0);
    cycle();
    read_chk("int_exl_epc", 5'd14, 32'h0000_3020);

    // Exception under EXL leaves no trace.
    drive_exc(5'd12, 32'h0000_5000, 1'b0);
    HWInt = 6'd0;
    req_chk("mask_req", 1'b0);
    cycle();
    read_chk("mask_epc", 5'd14, 32'h0000_3020);
    read_chk("mask_cause", 5'd13, 32'h0000_0000);

    // eret clears EXL; next exception is taken again (PC low bits dropped).
    @(negedge clk);
    eret = 1'b1;
    req_chk("eret_req", 1'b0);
    cycle();
    read_chk("eret_sr", 5'd12, 32'h0000_0401);
    drive_exc(5'd10, 32'h0000_6007, 1'b0);
    req_chk("ri_req", 1'b1);
    cycle();
    read_chk("ri_epc", 5'd14, 32'h0000_6004);
    read_chk("ri_cause", 5'd13, 32'h0000_0028);
    do_eret();

    // Collision: exception discards same-cycle mtc0 EPC and eret.
    drive_exc(5'd12, 32'h0000_7000, 1'b0);
    CP0_we    = 1'b1;
    CP0_addr  = 5'd14;
    CP0_wdata = 32'hDEAD_BEEC;
    eret      = 1'b1;
    req_chk("coll_req", 1'b1);
    cycle();
    read_chk("coll_epc", 5'd14, 32'h0000_7000);
    read_chk("coll_sr", 5'd12, 32'h0000_0403);
    do_eret();

    // Same mtc0 without a request lands; EPC_out is not bypassed.
    @(negedge clk);
    CP0_we    = 1'b1;
    CP0_addr  = 5'd14;
    CP0_wdata = 32'hDEAD_BEEC;
    req_chk("wr_epc_req", 1'b0);
    expect_val("wr_epc_nobypass", 32'h0000_7000);
    check(EPC_out);
    cycle();
    expect_val("wr_epc_out", 32'hDEAD_BEEC);
    check(EPC_out);

    // EPC wraps: PC 0 in a delay slot.
    drive_exc(5'd5, 32'h0000_0000, 1'b1);
    req_chk("wrap_req", 1'b1);
    cycle();
    read_chk("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    read_chk("wrap_cause", 5'd13, 32'h8000_0014);

    // eret with mtc0 SR: eret owns EXL, mtc0 writes IM/IE.
    @(negedge clk);
    eret      = 1'b1;
    CP0_we    = 1'b1;
    CP0_addr  = 5'd12;
    CP0_wdata = 32'h0000_0002;
    cycle();
    read_chk("eret_mtc0_sr", 5'd12, 32'h0000_0000);

    // Writes to Cause are ignored; PRId and unmapped reads.
    @(negedge clk);
    CP0_we    = 1'b1;
    CP0_addr  = 5'd13;
    CP0_wdata = 32'hFFFF_FFFF;
    cycle();
    read_chk("cause_ro", 5'd13, 32'h8000_0014);
    read_chk("prid", 5'd15, TB_PRID);
    read_chk("unmapped", 5'd3, 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    expect_val("async_rst_epc", 32'd0);
    check(EPC_out);
    read_chk("async_rst_cause", 5'd13, 32'd0);
    reset_n = 1'b1;

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover count=%0d", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
